// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state encoding and sample conversion helpers for the DAC feeder
package dac_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_UNDER = 2'd2
    } dac_state_e;

    // Offset-binary zero point for a dw-bit word (dw <= 32).
    function automatic logic [31:0] midscale(input int dw);
        return 32'd1 << (dw - 1);
    endfunction

    // Two's complement to offset binary is a flip of the sign bit.
    function automatic logic [31:0] to_offset_binary(input logic [31:0] s, input int dw);
        return s ^ midscale(dw);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with level/full/empty and synchronous flush
module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - paces buffered samples out to the serial DAC, one word per frame
module dac_sample_feeder
    import dac_pkg::*;
#(
    parameter int DW         = 16,
    parameter int DEPTH      = 8,
    parameter int FRAME_LEN  = 16,
    parameter int PREFILL    = 4,
    parameter int UNDER_HOLD = 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       soft_clr,
    input  logic [DW-1:0]              s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic [DW-1:0]              dac_data,
    output logic                       dac_en,
    output logic                       frame_tick,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                underrun_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [DW-1:0] MIDSCALE = DW'(midscale(DW));

    dac_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic [15:0]   urc_q, urc_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic [DW-1:0] fifo_rdata;
    logic [LW-1:0] fifo_lvl;
    logic          fifo_full;
    logic          fifo_empty;

    logic          prefilled;
    logic [CW-1:0] cnt_next;
    logic [DW-1:0] conv_word;
    logic [15:0]   urc_inc;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .flush (soft_clr),
        .push  (fifo_push),
        .wdata (s_tdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (fifo_lvl),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready is forced low while reset is held so nothing is accepted into a clearing FIFO.
    assign s_tready     = !fifo_full && !areset;
    assign fifo_push    = s_tvalid && s_tready && !soft_clr;
    assign dac_en       = (state_q != ST_FILL);
    assign frame_tick   = dac_en && (cnt_q == CW'(FRAME_LEN - 1));
    assign dac_data     = data_q;
    assign fifo_level   = fifo_lvl;
    assign underrun_cnt = urc_q;

    assign prefilled = (fifo_lvl >= LW'(PREFILL));
    assign cnt_next  = frame_tick ? '0 : cnt_q + CW'(1);
    assign conv_word = DW'(to_offset_binary(32'(fifo_rdata), DW));
    assign urc_inc   = (urc_q == 16'hFFFF) ? urc_q : urc_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        urc_d    = urc_q;
        fifo_pop = 1'b0;
        if (soft_clr) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            data_d  = MIDSCALE;
        end else begin
            case (state_q)
                ST_FILL: begin
                    cnt_d = '0;
                    // First word is popped on entry so dac_data is already valid when dac_en rises.
                    if (prefilled) begin
                        fifo_pop = 1'b1;
                        data_d   = conv_word;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_next;
                    if (frame_tick) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            data_d   = conv_word;
                        end else begin
                            state_d = ST_UNDER;
                            urc_d   = urc_inc;
                            if (UNDER_HOLD == 0) begin
                                data_d = MIDSCALE;
                            end
                        end
                    end
                end
                ST_UNDER: begin
                    cnt_d = cnt_next;
                    // Resume only once a full prefill is back, not on the first stray sample.
                    if (frame_tick) begin
                        if (prefilled) begin
                            fifo_pop = 1'b1;
                            data_d   = conv_word;
                            state_d  = ST_RUN;
                        end else begin
                            urc_d = urc_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    data_d  = MIDSCALE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            data_q  <= MIDSCALE;
            urc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            urc_q   <= urc_d;
        end
    end

endmodule
